hardware_top: RTL and testbench
===============================

Name: hardware_top

Overview:
Board-level top for the TinyFPGA-BX flash-driven LED blinker. After reset it wakes the on-board SPI flash (AT25SF081-compatible) and reads a 32-bit blink half-period word from a fixed flash address. It then toggles user_led forever at that rate. The USB and UART pins are parked at safe idle levels.

Parameters:
FLASH_ADDR, 24'h050000, byte address of the big-endian 32-bit half-period word
POWERUP_CYCLES, 1024, clocks to wait after reset before the first flash access
WAKE_GAP_CYCLES, 64, clocks with CS high after the 0xAB wake command (>= tRES1)
DEFAULT_HALF_PERIOD, 32'd8000000, fallback half-period in clocks (0.5 s at 16 MHz)

Ports:
clk_16mhz  in  1  system clock, 16 MHz; the only clock
resetn  in  1  asynchronous active-low reset
pin_pu  out  1  USB pull-up enable; constant 0 (USB detached)
pin_usbp  out  1  constant 0
pin_usbn  out  1  constant 0
pin_1  out  1  UART TX; constant 1 (idle mark)
pin_2  in  1  UART RX; ignored
user_led  out  1  LED, 1 = on
flash_csb  out  1  flash chip select, active low
flash_clk  out  1  SPI clock, mode 0
flash_io0  inout  1  MOSI; always driven by this block
flash_io1  inout  1  MISO; never driven (high-Z), sampled only
flash_io2  inout  1  WP_N; driven constant 1
flash_io3  inout  1  HOLD_N; driven constant 1

Behaviour:
- Reset values (async, resetn=0): flash_csb=1, flash_clk=0, flash_io0=0, user_led=0, state=PWR_WAIT, all counters cleared, half_period=0.
- SPI timing:
  - Each bit takes 2 clocks. Phase A: flash_clk=0 and io0 = current bit, MSB first. Phase B: flash_clk=1.
  - io1 is sampled on the clock edge that ends phase B.
  - CS falls one clock before the first phase A and rises one clock after the last phase B. flash_clk is 0 whenever CS is high.
- FSM:
  - PWR_WAIT: count POWERUP_CYCLES clocks, then go to WAKE.
  - WAKE: send 8 bits of 0xAB (Release Power-Down), raise CS, then go to GAP.
  - GAP: hold CS high for WAKE_GAP_CYCLES, then go to READ.
  - READ: in one CS-low frame, send 0x03 followed by FLASH_ADDR[23:0] (32 bits out), then clock 32 more bits while shifting io1 into rx[31:0], MSB first. io0 is held 0 during receive. Raise CS, then go to LOAD.
  - LOAD (1 clock): if rx==0 or rx==32'hFFFFFFFF, half_period=DEFAULT_HALF_PERIOD. Else if rx<2, half_period=2. Else half_period=rx. Then go to RUN.
  - RUN: counter increments each clock. When counter==half_period-1, toggle user_led and clear counter. No exit except reset.
- Consequences:
  - The first user_led rise occurs exactly half_period clocks after entering RUN.
  - The LED period is 2*half_period clocks at 50% duty.
- Reset mid-transfer: CS rises and flash_clk drops immediately (async). The sequence restarts from PWR_WAIT after release.
- pin_2 has no effect on any state.

Decomposition:
- Package hardware_top_pkg holds:
  - opcode constants OP_RDP=8'hAB and OP_READ=8'h03
  - state enum {PWR_WAIT, WAKE, GAP, READ, LOAD, RUN}
  - the erased-word constant 32'hFFFFFFFF
- One sub-module, flash_spi_master, handles CS/SCK/MOSI sequencing and MISO capture.
  - Interface: start, tx_bits count, rx_bits count, tx shift word, rx word out, done pulse.
  - The top FSM and LED counter stay in hardware_top.

Test Plan:
- Reset hold: resetn=0 for 10 clocks -> user_led=0, flash_csb=1, flash_clk=0, pin_pu=0, pin_1=1, io2=io3=1.
- Wake frame: after POWERUP_CYCLES -> exactly 16 flash_clk-relevant phases (8 rising edges) with io0 = 1,0,1,0,1,0,1,1 under a single CS-low window, then CS high for >= 64 clocks.
- Read with flash word 32'h00000100 at 0x050000 -> the frame sends 0x03,0x05,0x00,0x00 and then 32 read clocks. user_led rises 256 clocks after RUN entry and falls 256 clocks later; the testbench sees on/off twice.
- Erased flash (all 0xFF) -> half_period=8000000. First LED rise occurs 8000000 clocks after RUN entry.
- Word 32'h00000001 -> clamped to 2. LED toggles every 2 clocks.
- Assert resetn mid-READ (after 20 bits) -> CS high and flash_clk 0 in the same cycle. After release, a full PWR_WAIT, WAKE, READ sequence repeats and the LED resumes with the correct period.

Source files
------------

// File: rtl/hardware_top_pkg.sv
// Shared types and constants for the TinyFPGA-BX flash-driven blinker.
// Flash opcodes, FSM encodings and the half-period selection rule.
package hardware_top_pkg;

    localparam logic [7:0]  OP_RDP      = 8'hAB;
    localparam logic [7:0]  OP_READ     = 8'h03;
    localparam logic [31:0] ERASED_WORD = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        PWR_WAIT,
        WAKE,
        GAP,
        READ,
        LOAD,
        RUN
    } state_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PHA,
        S_PHB,
        S_TAIL
    } spi_state_t;

    // Blank or erased words fall back to the default; 1 is too short to toggle.
    function automatic logic [31:0] pick_half(
        input logic [31:0] rx,
        input logic [31:0] dflt
    );
        if (rx == 32'd0 || rx == ERASED_WORD) return dflt;
        else if (rx < 32'd2)                   return 32'd2;
        else                                   return rx;
    endfunction

endpackage

// File: rtl/flash_spi_master.sv
// Mode-0 SPI master: one CS-low frame of tx_bits out then rx_bits in.
// Two clocks per bit; MISO is sampled on the edge that ends the high phase.
module flash_spi_master
    import hardware_top_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  tx_bits,
    input  logic [5:0]  rx_bits,
    input  logic [31:0] tx_word,
    input  logic        miso,
    output logic        csb,
    output logic        sck,
    output logic        mosi,
    output logic [31:0] rx_word,
    output logic        done
);

    spi_state_t  st;
    logic [31:0] sr;
    logic [6:0]  cnt;
    logic [6:0]  txn;
    logic [6:0]  total;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= S_IDLE;
            csb     <= 1'b1;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
            txn     <= '0;
            total   <= '0;
            rx_word <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (st)
                S_IDLE: begin
                    if (start) begin
                        csb     <= 1'b0;
                        sck     <= 1'b0;
                        mosi    <= 1'b0;
                        sr      <= tx_word;
                        cnt     <= '0;
                        txn     <= {1'b0, tx_bits};
                        total   <= {1'b0, tx_bits} + {1'b0, rx_bits};
                        rx_word <= '0;
                        st      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    mosi <= (txn != 7'd0) & sr[31];
                    st   <= S_PHA;
                end
                S_PHA: begin
                    sck <= 1'b1;
                    st  <= S_PHB;
                end
                S_PHB: begin
                    sck <= 1'b0;
                    sr  <= {sr[30:0], 1'b0};
                    cnt <= cnt + 7'd1;
                    if (cnt >= txn) rx_word <= {rx_word[30:0], miso};
                    if (cnt + 7'd1 == total) begin
                        mosi <= 1'b0;
                        st   <= S_TAIL;
                    end else begin
                        mosi <= (cnt + 7'd1 < txn) & sr[30];
                        st   <= S_PHA;
                    end
                end
                S_TAIL: begin
                    csb  <= 1'b1;
                    done <= 1'b1;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/hardware_top.sv
// TinyFPGA-BX top: wake the SPI flash, fetch a half-period word, blink user_led.
// USB is detached and UART TX idles at mark.
module hardware_top
    import hardware_top_pkg::*;
#(
    parameter logic [23:0] FLASH_ADDR          = 24'h050000,
    parameter int          POWERUP_CYCLES      = 1024,
    parameter int          WAKE_GAP_CYCLES     = 64,
    parameter logic [31:0] DEFAULT_HALF_PERIOD = 32'd8000000
) (
    input  logic clk_16mhz,
    input  logic resetn,
    output logic pin_pu,
    output logic pin_usbp,
    output logic pin_usbn,
    output logic pin_1,
    input  logic pin_2,
    output logic user_led,
    output logic flash_csb,
    output logic flash_clk,
    inout  wire  flash_io0,
    inout  wire  flash_io1,
    inout  wire  flash_io2,
    inout  wire  flash_io3
);

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] half_period;
    logic        spi_start;
    logic [5:0]  spi_tx_bits;
    logic [5:0]  spi_rx_bits;
    logic [31:0] spi_tx_word;
    logic [31:0] spi_rx_word;
    logic        spi_done;
    logic        spi_mosi;
    logic        unused_pin_2;

    assign pin_pu       = 1'b0;
    assign pin_usbp     = 1'b0;
    assign pin_usbn     = 1'b0;
    assign pin_1        = 1'b1;
    assign unused_pin_2 = pin_2;
    assign flash_io0    = spi_mosi;
    assign flash_io2    = 1'b1;
    assign flash_io3    = 1'b1;

    flash_spi_master u_spi (
        .clk     (clk_16mhz),
        .rst_n   (resetn),
        .start   (spi_start),
        .tx_bits (spi_tx_bits),
        .rx_bits (spi_rx_bits),
        .tx_word (spi_tx_word),
        .miso    (flash_io1),
        .csb     (flash_csb),
        .sck     (flash_clk),
        .mosi    (spi_mosi),
        .rx_word (spi_rx_word),
        .done    (spi_done)
    );

    always_ff @(posedge clk_16mhz or negedge resetn) begin
        if (!resetn) begin
            state       <= PWR_WAIT;
            cnt         <= '0;
            half_period <= '0;
            user_led    <= 1'b0;
            spi_start   <= 1'b0;
            spi_tx_bits <= '0;
            spi_rx_bits <= '0;
            spi_tx_word <= '0;
        end else begin
            spi_start <= 1'b0;
            unique case (state)
                PWR_WAIT: begin
                    if (cnt == 32'(POWERUP_CYCLES - 1)) begin
                        cnt         <= '0;
                        spi_start   <= 1'b1;
                        spi_tx_word <= {OP_RDP, 24'h0};
                        spi_tx_bits <= 6'd8;
                        spi_rx_bits <= 6'd0;
                        state       <= WAKE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                WAKE: begin
                    if (spi_done) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == 32'(WAKE_GAP_CYCLES - 1)) begin
                        cnt         <= '0;
                        spi_start   <= 1'b1;
                        spi_tx_word <= {OP_READ, FLASH_ADDR};
                        spi_tx_bits <= 6'd32;
                        spi_rx_bits <= 6'd32;
                        state       <= READ;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                READ: begin
                    if (spi_done) state <= LOAD;
                end
                LOAD: begin
                    half_period <= pick_half(spi_rx_word, DEFAULT_HALF_PERIOD);
                    cnt         <= '0;
                    state       <= RUN;
                end
                RUN: begin
                    if (cnt == half_period - 32'd1) begin
                        user_led <= ~user_led;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_hardware_top.sv
// Scoreboard bench for hardware_top: a flash model answers the read,
// frames and LED edges are checked against a queue of expected events.
module tb_hardware_top;

    localparam logic [31:0] DFLT = 32'd600;

    typedef struct {
        bit          is_led;
        logic [63:0] data;
        int          nbits;
        int          delta;
    } exp_t;

    logic clk_16mhz = 1'b0;
    logic resetn    = 1'b0;
    logic pin_2     = 1'b0;
    logic miso      = 1'b0;
    logic pin_pu, pin_usbp, pin_usbn, pin_1, user_led;
    logic flash_csb, flash_clk;
    wire  flash_io0, flash_io1, flash_io2, flash_io3;

    assign flash_io1 = miso;

    hardware_top #(.DEFAULT_HALF_PERIOD(DFLT)) dut (
        .clk_16mhz (clk_16mhz),
        .resetn    (resetn),
        .pin_pu    (pin_pu),
        .pin_usbp  (pin_usbp),
        .pin_usbn  (pin_usbn),
        .pin_1     (pin_1),
        .pin_2     (pin_2),
        .user_led  (user_led),
        .flash_csb (flash_csb),
        .flash_clk (flash_clk),
        .flash_io0 (flash_io0),
        .flash_io1 (flash_io1),
        .flash_io2 (flash_io2),
        .flash_io3 (flash_io3)
    );

    always #5 clk_16mhz = ~clk_16mhz;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    exp_t exp_q[$];
    logic [31:0] flash_word = 32'h0;

    always @(posedge clk_16mhz) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // monitor / flash model state
    logic [63:0] fbits;
    int  nedge = 0;
    int  frames = 0;
    int  sck_bad = 0;
    int  t_csrise = 0;
    int  t_last = 0;
    bit  in_frame = 0;
    logic prev_csb = 1'b1, prev_sck = 1'b0, prev_led = 1'b0;

    always @(negedge clk_16mhz) begin
        exp_t e;
        if (!resetn) begin
            in_frame = 0;
            nedge    = 0;
            frames   = 0;
            sck_bad  = 0;
            miso     = 1'b0;
            prev_csb = 1'b1;
            prev_sck = 1'b0;
            prev_led = 1'b0;
        end else begin
            if (prev_csb && !flash_csb) begin
                in_frame = 1;
                nedge    = 0;
                fbits    = '0;
                if (frames > 0)
                    check("cs_gap_ge64", 64'((cyc - t_csrise) >= 64), 64'd1);
            end
            if (flash_csb && flash_clk) sck_bad++;
            if (!flash_csb && !prev_sck && flash_clk) begin
                fbits = {fbits[62:0], flash_io0};
                nedge++;
            end
            if (!prev_csb && flash_csb && in_frame) begin
                in_frame = 0;
                frames++;
                t_csrise = cyc;
                if (nedge == 64) t_last = cyc;
                check("sck_idle_low", 64'(sck_bad), 64'd0);
                sck_bad = 0;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 64'(nedge), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_kind", 64'(e.is_led), 64'd0);
                    check("frame_bits", 64'(nedge), 64'(e.nbits));
                    check("frame_data", fbits, e.data);
                end
            end
            if (user_led !== prev_led) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_led", 64'(user_led), 64'(prev_led));
                end else begin
                    e = exp_q.pop_front();
                    check("led_kind", 64'(e.is_led), 64'd1);
                    check("led_val", 64'(user_led), e.data);
                    check("led_delta", 64'(cyc - t_last), 64'(e.delta));
                end
                t_last = cyc;
            end
            if (!flash_csb && !flash_clk && nedge >= 32 && nedge < 64)
                miso = flash_word[63 - nedge];
            prev_csb = flash_csb;
            prev_sck = flash_clk;
            prev_led = user_led;
        end
    end

    initial forever begin
        @(negedge clk_16mhz);
        pin_2 = 1'($urandom_range(0, 1));
    end

    task automatic push_frame(input logic [63:0] d, input int n);
        exp_t e;
        e.is_led = 0; e.data = d; e.nbits = n; e.delta = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_led(input logic v, input int d);
        exp_t e;
        e.is_led = 1; e.data = 64'(v); e.nbits = 0; e.delta = d;
        exp_q.push_back(e);
    endtask

    task automatic push_run(input int h, input int edges);
        push_frame(64'hAB, 8);
        push_frame({8'h03, 24'h050000, 32'h0}, 64);
        for (int i = 0; i < edges; i++)
            push_led(~i[0], (i == 0) ? h + 2 : h);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_16mhz);
            if (exp_q.size() == 0) break;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic start_run(input logic [31:0] w);
        #1 resetn = 1'b0;
        flash_word = w;
        repeat (10) @(posedge clk_16mhz);
        #1 resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        repeat (10) @(posedge clk_16mhz);
        #1;
        check("rst_led", 64'(user_led), 64'd0);
        check("rst_csb", 64'(flash_csb), 64'd1);
        check("rst_sck", 64'(flash_clk), 64'd0);
        check("rst_io0", 64'(flash_io0), 64'd0);
        check("pin_pu", 64'(pin_pu), 64'd0);
        check("pin_usb", 64'({pin_usbp, pin_usbn}), 64'd0);
        check("pin_1", 64'(pin_1), 64'd1);
        check("io2_io3", 64'({flash_io2, flash_io3}), 64'd3);

        start_run(32'h00000100);
        push_run(256, 4);
        wait_drain(5000);

        start_run(32'hFFFFFFFF);
        push_run(int'(DFLT), 2);
        wait_drain(5000);

        start_run(32'h00000001);
        push_run(2, 4);
        wait_drain(5000);

        start_run(32'h00000000);
        push_run(int'(DFLT), 2);
        wait_drain(5000);

        start_run(32'h00000100);
        push_frame(64'hAB, 8);
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk_16mhz);
            if (frames == 1 && nedge >= 20) break;
        end
        check("reached_read_bit20", 64'(frames == 1 && nedge >= 20), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_csb", 64'(flash_csb), 64'd1);
        check("mid_rst_sck", 64'(flash_clk), 64'd0);
        check("mid_rst_q", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        start_run(32'h00000100);
        push_run(256, 2);
        wait_drain(5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
